// File: rtl/riscv_v_pipe_pkg.sv
// Shared definitions for the elastic vector pipe: default fill values for
// the reset and flush payloads, and the occupancy counter width helper.
package riscv_v_pipe_pkg;

    // Fill bit replicated across the payload width for the default reset value.
    localparam logic RST_FILL_BIT   = 1'b0;
    // Fill bit replicated across the payload width for the default flush value.
    localparam logic FLUSH_FILL_BIT = 1'b0;

    // Bits needed to count 0..num_slots valid slots.
    function automatic int occ_width(input int num_slots);
        if (num_slots < 1) begin
            return 1;
        end
        return $clog2(num_slots + 1);
    endfunction

endpackage

// File: rtl/riscv_v_pipe_slot.sv
// One register slot of the elastic pipe: a valid bit, a payload register and
// the local ready term that lets a bubble collapse when the slot is empty.
module riscv_v_pipe_slot
    import riscv_v_pipe_pkg::*;
#(
    parameter int               WIDTH     = 6,
    parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{RST_FILL_BIT}},
    parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{FLUSH_FILL_BIT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic ready;

    // An empty slot, or one whose occupant moves on this cycle, can take a new payload.
    assign ready = !valid || down_ready;

    // Valid/payload update: flush beats any transfer; payload moves only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RST_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= FLUSH_VAL;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/riscv_v_elastic_pipe.sv
// Elastic, bubble-collapsing register pipe of NUM_STAGES slots with a
// combinational ready chain, synchronous flush and asynchronous reset.
module riscv_v_elastic_pipe
    import riscv_v_pipe_pkg::*;
#(
    parameter int               WIDTH      = 6,
    parameter int               NUM_STAGES = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{RST_FILL_BIT}},
    parameter logic [WIDTH-1:0] FLUSH_VAL  = {WIDTH{FLUSH_FILL_BIT}}
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic [occ_width(NUM_STAGES)-1:0]    occupancy
);

    localparam int OCC_W = occ_width(NUM_STAGES);

    logic [NUM_STAGES-1:0] slot_valid;
    logic [WIDTH-1:0]      slot_data [NUM_STAGES];
    logic [NUM_STAGES:0]   chain_ready;
    logic [OCC_W-1:0]      occ_sum;

    // Ready chain from the output back to slot 1; index k is slot k+1, top index is out_ready.
    always_comb begin
        chain_ready             = '0;
        chain_ready[NUM_STAGES] = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            chain_ready[k] = !slot_valid[k] || chain_ready[k + 1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = slot_valid[k - 1];
            assign up_data  = slot_data[k - 1];
        end

        riscv_v_pipe_slot #(
            .WIDTH     (WIDTH),
            .RST_VAL   (RST_VAL),
            .FLUSH_VAL (FLUSH_VAL)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (chain_ready[k + 1]),
            .valid      (slot_valid[k]),
            .data       (slot_data[k])
        );
    end

    // Population count of the registered slot valid bits.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occ_sum = occ_sum + OCC_W'(slot_valid[k]);
        end
    end

    // Input is refused while held in reset or while a flush is killing the pipe.
    assign in_ready  = chain_ready[0] && !flush && rst_n;
    assign out_valid = slot_valid[NUM_STAGES - 1];
    assign out_data  = slot_data[NUM_STAGES - 1];
    assign occupancy = occ_sum;

endmodule
